gshare_bp_param: RTL

- Parametrised next-generation dynamic branch predictor for the 32b MIPS pipeline.
- Generalises the fixed 5-bit correlational predictor in four ways:
  - configurable PHT depth, history length and counter width;
  - selectable index hashing mode;
  - speculative global-history update at predict time, with checkpoint/recovery on mispredict;
  - a saturating mispredict statistics counter.
- Lookup happens in IF; resolution comes from ID.

---
 rtl/gshare_bp_pkg.sv | 44 ++++
 rtl/bp_pht_sat_ctr_array.sv | 47 ++++
 rtl/gshare_bp_param.sv | 119 +++++++++++
 3 files changed

// File: rtl/gshare_bp_pkg.sv
// ----------------------------------------------------------------------------
// gshare_bp_pkg : shared types and counter helpers for the gshare predictor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gshare_bp_pkg;

  typedef enum logic [1:0] {
    BP_GSHARE  = 2'd0,
    BP_BIMODAL = 2'd1,
    BP_GSELECT = 2'd2
  } bp_mode_e;

  localparam int BP_MAX_IDX_W = 16;
  localparam int BP_MAX_CTR_W = 4;

  typedef struct packed {
    logic [BP_MAX_IDX_W-1:0] idx;
    logic [BP_MAX_IDX_W-1:0] ghr;
  } bp_ckpt_t;

  // Weakly not-taken: the value just below the taken threshold.
  function automatic logic [BP_MAX_CTR_W-1:0] ctr_init(input int ctr_w);
    return 4'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic logic [BP_MAX_CTR_W-1:0] ctr_sat_upd(
    input logic [BP_MAX_CTR_W-1:0] ctr,
    input logic                    taken,
    input int                      ctr_w
  );
    logic [BP_MAX_CTR_W-1:0] max_v;
    logic [BP_MAX_CTR_W-1:0] res;
    max_v = 4'((1 << ctr_w) - 1);
    res   = ctr;
    if (taken && (ctr != max_v)) res = ctr + 4'd1;
    else if (!taken && (ctr != 4'd0)) res = ctr - 4'd1;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_pht_sat_ctr_array.sv
// ----------------------------------------------------------------------------
// bp_pht_sat_ctr_array : PHT of saturating counters, async read, sync update
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bp_pht_sat_ctr_array
  import gshare_bp_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [CTR_W-1:0] o_rd_ctr,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int                      c_depth = 1 << IDX_W;
  localparam logic [BP_MAX_CTR_W-1:0] c_init  = ctr_init(CTR_W);

  logic [CTR_W-1:0]        r_pht [c_depth];
  logic [BP_MAX_CTR_W-1:0] w_wr_cur;
  logic [BP_MAX_CTR_W-1:0] w_wr_nxt;

  // No bypass: a same-cycle read observes the pre-update counter.
  assign o_rd_ctr = r_pht[i_rd_idx];

  assign w_wr_cur = BP_MAX_CTR_W'(r_pht[i_wr_idx]);
  assign w_wr_nxt = ctr_sat_upd(w_wr_cur, i_wr_taken, CTR_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_pht[i] <= c_init[CTR_W-1:0];
      end
    end else if (i_wr_en) begin
      r_pht[i_wr_idx] <= w_wr_nxt[CTR_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/gshare_bp_param.sv
// ----------------------------------------------------------------------------
// gshare_bp_param : parametrised gshare/bimodal/gselect branch predictor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gshare_bp_param
  import gshare_bp_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PC_LSB = 2,
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8,
  parameter int CTR_W  = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_req_i,
  input  logic [PC_W-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  output logic [HIST_W-1:0] pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic              upd_stall_i,
  input  logic [IDX_W-1:0]  upd_idx_i,
  input  logic [HIST_W-1:0] upd_ghr_i,
  input  logic              upd_pred_i,
  input  logic              upd_taken_i,
  output logic              mispredict_o,
  output logic [HIST_W-1:0] ghr_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam bp_mode_e c_mode = bp_mode_e'(MODE);

  logic [HIST_W-1:0] r_ghr;
  logic [CNT_W-1:0]  r_cnt;
  logic [HIST_W-1:0] w_ghr_nxt;
  logic [HIST_W-1:0] w_ghr_rec;
  logic [HIST_W-1:0] w_ghr_shift;
  logic [IDX_W-1:0]  w_pcbits;
  logic [IDX_W-1:0]  w_idx;
  logic [CTR_W-1:0]  w_ctr;
  logic              w_upd_fire;
  logic              w_mispredict;
  logic              w_unused;

  assign w_unused   = ^{pred_pc_i, upd_ghr_i};
  assign w_pcbits   = pred_pc_i[PC_LSB +: IDX_W];
  assign w_upd_fire = upd_valid_i & ~upd_stall_i;
  assign w_mispredict = w_upd_fire & (upd_pred_i != upd_taken_i);

  generate
    if (c_mode == BP_BIMODAL) begin : g_idx_bimodal
      assign w_idx = w_pcbits;
    end else if (c_mode == BP_GSELECT) begin : g_idx_gselect
      if (HIST_W == IDX_W) begin : g_ghr_only
        assign w_idx = r_ghr;
      end else begin : g_pc_ghr
        assign w_idx = {pred_pc_i[PC_LSB +: IDX_W-HIST_W], r_ghr};
      end
    end else begin : g_idx_gshare
      assign w_idx = w_pcbits ^ IDX_W'(r_ghr);
    end
  endgenerate

  bp_pht_sat_ctr_array #(
    .IDX_W (IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_ctr   (w_ctr),
    .i_wr_en    (w_upd_fire),
    .i_wr_idx   (upd_idx_i),
    .i_wr_taken (upd_taken_i)
  );

  assign pred_taken_o = w_ctr[CTR_W-1] & pred_req_i;
  assign pred_idx_o   = w_idx;
  assign pred_ghr_o   = r_ghr;

  generate
    if (HIST_W == 1) begin : g_ghr_one
      assign w_ghr_rec   = upd_taken_i;
      assign w_ghr_shift = pred_taken_o;
    end else begin : g_ghr_wide
      assign w_ghr_rec   = {upd_ghr_i[HIST_W-2:0], upd_taken_i};
      assign w_ghr_shift = {r_ghr[HIST_W-2:0], pred_taken_o};
    end
  endgenerate

  // Recovery beats the speculative shift: the same-cycle IF branch is flushed.
  always_comb begin
    w_ghr_nxt = r_ghr;
    if (w_mispredict) w_ghr_nxt = w_ghr_rec;
    else if (pred_req_i) w_ghr_nxt = w_ghr_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
      r_cnt <= '0;
    end else begin
      r_ghr <= w_ghr_nxt;
      if (w_mispredict && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mispredict_o  = w_mispredict;
  assign ghr_o         = r_ghr;
  assign mispred_cnt_o = r_cnt;

endmodule

`default_nettype wire
